// File: rtl/sme_seq_pkg.sv
// Shared types and default sizing for the string-match job sequencer.
// Holds the FSM state encoding and the buffer/timeout defaults.
package sme_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_GAP,
        ST_WAIT,
        ST_RESULT
    } seq_state_t;

    localparam int STR_MAX    = 32;
    localparam int PAT_MAX    = 8;
    localparam int WAIT_LIMIT = 255;
    localparam int CHAR_W     = 8;
    localparam int INDEX_W    = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sme_job_sequencer_if.sv
// Host, engine and result signals of the job sequencer bundled in one interface.
// Handshakes: a host character or a result moves only on a cycle where valid and ready are both high; valid never waits on ready.
interface sme_job_sequencer_if;
    import sme_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [CHAR_W-1:0]  in_char;
    logic               in_type;
    logic               in_last;
    logic [CHAR_W-1:0]  eng_chardata;
    logic               eng_isstring;
    logic               eng_ispattern;
    logic               eng_valid;
    logic               eng_match;
    logic [INDEX_W-1:0] eng_match_index;
    logic               res_valid;
    logic               res_ready;
    logic               res_match;
    logic [INDEX_W-1:0] res_index;
    logic               res_err;
    logic               busy;
    seq_state_t         dbg_state;

    modport slave (
        input  in_valid, in_char, in_type, in_last, eng_valid, eng_match, eng_match_index, res_ready,
        output in_ready, eng_chardata, eng_isstring, eng_ispattern, res_valid, res_match, res_index,
               res_err, busy, dbg_state
    );

    modport master (
        output in_valid, in_char, in_type, in_last, eng_valid, eng_match, eng_match_index, res_ready,
        input  in_ready, eng_chardata, eng_isstring, eng_ispattern, res_valid, res_match, res_index,
               res_err, busy, dbg_state
    );

endinterface

// File: rtl/sme_char_buf.sv
// Append-only character buffer with saturating length and a combinational read port.
// clear restarts the buffer; a write in the same cycle lands at position 0.
module sme_char_buf import sme_seq_pkg::*; #(
    parameter  int DEPTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic [LW-1:0]     len,
    output logic              drop
);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [LW-1:0]     ptr;
    logic              room;

    assign ptr     = clear ? '0 : len;
    assign room    = (ptr != LW'(DEPTH));
    assign drop    = we && !room;
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else if (we && room) begin
            len <= ptr + LW'(1);
        end else begin
            len <= ptr;
        end
    end

    // Contents are not reset; only the length decides what is valid.
    always_ff @(posedge clk) begin
        if (we && room) begin
            mem[ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sme_job_sequencer.sv
// Collects string/pattern characters from a host, replays them to a matching engine
// and returns the engine's verdict (or an error) through a held result handshake.
module sme_job_sequencer #(
    parameter int STR_MAX    = sme_seq_pkg::STR_MAX,
    parameter int PAT_MAX    = sme_seq_pkg::PAT_MAX,
    parameter int WAIT_LIMIT = sme_seq_pkg::WAIT_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    sme_job_sequencer_if.slave sif
);
    import sme_seq_pkg::*;

    localparam int SAW   = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PAW   = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int SLW   = $clog2(STR_MAX + 1);
    localparam int PLW   = $clog2(PAT_MAX + 1);
    localparam int IDX_W = $clog2(max_int(STR_MAX, PAT_MAX) + 1);
    localparam int WC_W  = $clog2(WAIT_LIMIT + 1);

    seq_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [WC_W-1:0]    wait_cnt;
    logic               str_new, str_open, str_loaded, overflow;
    logic               res_valid, res_match, res_err;
    logic [INDEX_W-1:0] res_index;

    logic               str_we, pat_we, str_clear, handshake, str_drop, pat_drop;
    logic [CHAR_W-1:0]  str_rd, pat_rd;
    logic [SLW-1:0]     str_len;
    logic [PLW-1:0]     pat_len;
    logic [IDX_W-1:0]   str_last_idx, pat_last_idx;

    assign str_we       = (state == ST_LOAD) && sif.in_valid && !sif.in_type;
    assign pat_we       = (state == ST_LOAD) && sif.in_valid && sif.in_type;
    assign handshake    = (state == ST_RESULT) && sif.res_ready;
    // A string character that arrives while no string is open starts a fresh one.
    assign str_clear    = str_we && !str_open;
    assign str_last_idx = IDX_W'(str_len) - IDX_W'(1);
    assign pat_last_idx = IDX_W'(pat_len) - IDX_W'(1);

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk(clk), .reset(reset), .clear(str_clear), .we(str_we), .wdata(sif.in_char),
        .rd_addr(idx[SAW-1:0]), .rd_data(str_rd), .len(str_len), .drop(str_drop)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk(clk), .reset(reset), .clear(handshake), .we(pat_we), .wdata(sif.in_char),
        .rd_addr(idx[PAW-1:0]), .rd_data(pat_rd), .len(pat_len), .drop(pat_drop)
    );

    assign sif.in_ready      = (state == ST_LOAD);
    assign sif.busy          = (state != ST_LOAD);
    assign sif.eng_isstring  = (state == ST_SEND_STR);
    assign sif.eng_ispattern = (state == ST_SEND_PAT);
    assign sif.eng_chardata  = (state == ST_SEND_STR) ? str_rd :
                               (state == ST_SEND_PAT) ? pat_rd : '0;
    assign sif.res_valid     = res_valid;
    assign sif.res_match     = res_match;
    assign sif.res_index     = res_index;
    assign sif.res_err       = res_err;
    assign sif.dbg_state     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            idx        <= '0;
            wait_cnt   <= '0;
            str_new    <= 1'b0;
            str_open   <= 1'b0;
            str_loaded <= 1'b0;
            overflow   <= 1'b0;
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_index  <= '0;
            res_err    <= 1'b0;
        end else begin
            if (str_we) begin
                str_open   <= !sif.in_last;
                str_loaded <= 1'b1;
                if (!str_open) str_new <= 1'b1;
            end
            if (str_drop || pat_drop) overflow <= 1'b1;

            case (state)
                ST_LOAD: begin
                    if (pat_we && sif.in_last) begin
                        idx <= '0;
                        if (str_new) begin
                            state <= ST_SEND_STR;
                        end else if (str_loaded) begin
                            state <= ST_SEND_PAT;
                        end else begin
                            state     <= ST_RESULT;
                            res_valid <= 1'b1;
                            res_match <= 1'b0;
                            res_index <= '0;
                            res_err   <= 1'b1;
                        end
                    end
                end
                ST_SEND_STR: begin
                    if (idx == str_last_idx) begin
                        idx     <= '0;
                        str_new <= 1'b0;
                        state   <= ST_SEND_PAT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_SEND_PAT: begin
                    if (idx == pat_last_idx) begin
                        idx   <= '0;
                        state <= ST_GAP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_GAP: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An engine answer on the last allowed cycle still wins over the timeout.
                    if (sif.eng_valid) begin
                        res_valid <= 1'b1;
                        res_match <= sif.eng_match;
                        res_index <= sif.eng_match_index;
                        res_err   <= overflow;
                        state     <= ST_RESULT;
                    end else if (wait_cnt == WC_W'(WAIT_LIMIT - 1)) begin
                        res_valid <= 1'b1;
                        res_match <= 1'b0;
                        res_index <= '0;
                        res_err   <= 1'b1;
                        state     <= ST_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (sif.res_ready) begin
                        res_valid <= 1'b0;
                        res_match <= 1'b0;
                        res_index <= '0;
                        res_err   <= 1'b0;
                        overflow  <= 1'b0;
                        str_open  <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Randomized job-level bench for sme_job_sequencer with a queue-based reference of
// string/pattern buffers, engine strobe order and result rules.
module tb_sme_job_sequencer;
    import sme_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_job_sequencer_if sif ();

    sme_job_sequencer #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .sif(sif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] str_item[$];
    logic [7:0] pat_item[$];
    // Reference: what the string buffer holds and which flags a job will see.
    logic [7:0] m_str[$];
    bit         m_loaded, m_new, m_ovf;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_item(input bit is_pat, input string s);
        if (is_pat) pat_item.delete(); else str_item.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (is_pat) pat_item.push_back(s[i]); else str_item.push_back(s[i]);
        end
    endtask

    task automatic rand_item(input bit is_pat, input int n);
        if (is_pat) pat_item.delete(); else str_item.delete();
        for (int i = 0; i < n; i++) begin
            if (is_pat) pat_item.push_back(8'($urandom_range(33, 126)));
            else        str_item.push_back(8'($urandom_range(33, 126)));
        end
    endtask

    task automatic model_reset();
        m_str.delete();
        m_loaded = 0;
        m_new    = 0;
        m_ovf    = 0;
    endtask

    // Drives one item with random host gaps and random (to-be-ignored) engine strobes.
    task automatic send_item(input bit is_pat);
        logic [7:0] q[$];
        if (is_pat) q = pat_item; else q = str_item;
        for (int i = 0; i < q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sif.in_valid = 1'b0;
                @(negedge clk);
            end
            sif.in_valid  = 1'b1;
            sif.in_char   = q[i];
            sif.in_type   = is_pat;
            sif.in_last   = (i == q.size() - 1);
            sif.eng_valid = 1'($urandom_range(0, 1));
            sif.eng_match = 1'($urandom_range(0, 1));
            check("in_ready_load", sif.in_ready, 1);
            @(negedge clk);
        end
        sif.in_valid  = 1'b0;
        sif.in_last   = 1'b0;
        sif.eng_valid = 1'b0;
        if (!is_pat) begin
            m_str.delete();
            for (int i = 0; i < q.size(); i++) begin
                if (i < STR_MAX) m_str.push_back(q[i]); else m_ovf = 1;
            end
            m_new    = 1;
            m_loaded = 1;
        end
    endtask

    // k: WAIT cycle on which the engine answers, -1 for never.
    task automatic run_job(input bit has_str, input int k, input bit mt, input logic [4:0] mi, input int rdly);
        bit         missing, gap_seen;
        int         n, c;
        logic       exp_m, exp_e;
        logic [4:0] exp_i;
        if (has_str) send_item(0);
        exp_q.delete();
        obs_q.delete();
        missing = !m_loaded;
        if (!missing) begin
            if (m_new) foreach (m_str[i]) exp_q.push_back({1'b0, m_str[i]});
            for (int i = 0; i < pat_item.size() && i < PAT_MAX; i++) exp_q.push_back({1'b1, pat_item[i]});
        end
        if (pat_item.size() > PAT_MAX) m_ovf = 1;
        send_item(1);

        gap_seen = 0;
        n = 0;
        while (!gap_seen && !sif.res_valid && n < 200) begin
            check("strobe_excl", 32'(sif.eng_isstring & sif.eng_ispattern), 0);
            if (sif.eng_isstring) obs_q.push_back({1'b0, sif.eng_chardata});
            else if (sif.eng_ispattern) obs_q.push_back({1'b1, sif.eng_chardata});
            else if (obs_q.size() > 0) begin
                gap_seen = 1;
                check("gap_chardata", sif.eng_chardata, 0);
                check("gap_busy", sif.busy, 1);
                check("gap_in_ready", sif.in_ready, 0);
            end
            if (!gap_seen) begin
                sif.eng_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
        end
        check("strobe_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check("strobe_char", obs_q[i], exp_q[i]);
        end
        check("gap_seen", gap_seen, !missing);

        if (missing) begin
            exp_m = 0; exp_i = '0; exp_e = 1;
        end else begin
            // Engine strobe during the gap cycle must be ignored.
            sif.eng_valid       = 1'b1;
            sif.eng_match       = !mt;
            sif.eng_match_index = ~mi;
            @(negedge clk);
            c = 0;
            while (!sif.res_valid && c <= WAIT_LIMIT + 4) begin
                sif.eng_valid       = (c == k);
                sif.eng_match       = (c == k) ? mt : 1'($urandom_range(0, 1));
                sif.eng_match_index = (c == k) ? mi : 5'($urandom_range(0, 31));
                @(negedge clk);
                c++;
            end
            sif.eng_valid = 1'b0;
            check("wait_cycles", c, (k >= 0) ? k + 1 : WAIT_LIMIT);
            if (k >= 0) begin
                exp_m = mt; exp_i = mi; exp_e = m_ovf;
            end else begin
                exp_m = 0; exp_i = '0; exp_e = 1;
            end
        end

        for (int d = 0; d <= rdly; d++) begin
            check("res_valid", sif.res_valid, 1);
            check("res_match", sif.res_match, exp_m);
            check("res_index", sif.res_index, exp_i);
            check("res_err", sif.res_err, exp_e);
            sif.res_ready = (d == rdly);
            sif.eng_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        sif.res_ready = 1'b0;
        sif.eng_valid = 1'b0;
        check("post_res_valid", sif.res_valid, 0);
        check("post_in_ready", sif.in_ready, 1);
        check("post_busy", sif.busy, 0);
        if (!missing) m_new = 0;
        m_ovf = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, n, slen, plen, k;
        bit has_str;
        reset = 1'b1;
        sif.in_valid = 0; sif.in_char = 0; sif.in_type = 0; sif.in_last = 0;
        sif.eng_valid = 0; sif.eng_match = 0; sif.eng_match_index = 0; sif.res_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", sif.in_ready, 1);
        check("rst_busy", sif.busy, 0);
        check("rst_state", sif.dbg_state, ST_LOAD);
        check("rst_eng", {sif.eng_isstring, sif.eng_ispattern, sif.eng_chardata}, 0);
        check("rst_res", {sif.res_valid, sif.res_match, sif.res_index, sif.res_err}, 0);

        // Pattern with no string loaded since reset.
        set_item(1, "x");
        run_job(0, 0, 0, 0, 2);

        set_item(0, "ab cd");
        set_item(1, "cd");
        run_job(1, $urandom_range(0, 10), 1, 5'd3, 1);

        // Reuse the stored string.
        set_item(1, "^a");
        run_job(0, $urandom_range(0, 10), 1, 5'd0, 0);

        rand_item(1, 10);
        run_job(0, $urandom_range(0, 10), 1, 5'd7, 0);

        rand_item(0, 40);
        rand_item(1, 3);
        run_job(1, 4, 0, 5'd0, 1);

        rand_item(0, 12);
        rand_item(1, 4);
        run_job(1, -1, 0, 5'd0, 0);

        // Engine answers on the very last allowed WAIT cycle.
        rand_item(1, 2);
        run_job(0, WAIT_LIMIT - 1, 1, 5'd17, 0);

        for (int j = 0; j < 10; j++) begin
            has_str = (j == 0) || ($urandom_range(0, 1) == 1);
            slen = $urandom_range(1, 36);
            plen = $urandom_range(1, 10);
            k = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 30);
            if (has_str) rand_item(0, slen);
            rand_item(1, plen);
            run_job(has_str, k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 4));
        end

        rand_item(1, 3);
        run_job(0, 2, 1, 5'd9, 5);

        // Abort the next job part-way through the string replay.
        rand_item(0, 10);
        rand_item(1, 3);
        send_item(0);
        send_item(1);
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 50) begin
            if (sif.eng_isstring) cnt++;
            if (cnt < 3) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_point", cnt, 3);
        reset = 1'b1;
        #1;
        check("abort_eng", {sif.eng_isstring, sif.eng_ispattern, sif.eng_chardata}, 0);
        check("abort_res", {sif.res_valid, sif.res_match, sif.res_index, sif.res_err}, 0);
        check("abort_busy", sif.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_idle", {sif.eng_isstring, sif.eng_ispattern, sif.busy}, 0);
        end
        check("abort_in_ready", sif.in_ready, 1);

        set_item(1, "x");
        run_job(0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme_job_sequencer.md
SME_JOB_SEQUENCER -- requirements
Module: sme_job_sequencer

Interface
REQ-001 SHALL have parameter STR_MAX, default 32, string buffer depth in characters.
REQ-002 SHALL have parameter PAT_MAX, default 8, pattern buffer depth in characters.
REQ-003 SHALL have parameter WAIT_LIMIT, default 255, maximum cycles to wait for eng_valid.
REQ-004 SHALL have the following ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  host character valid.
- in_ready  output  1  host character accepted when in_valid&in_ready.
- in_char  input  8  host character.
- in_type  input  1  0 = string item, 1 = pattern item.
- in_last  input  1  last character of current item.
- eng_chardata  output  8  character to matching engine.
- eng_isstring  output  1  string character strobe to engine.
- eng_ispattern  output  1  pattern character strobe to engine.
- eng_valid  input  1  engine result strobe.
- eng_match  input  1  engine match flag.
- eng_match_index  input  5  engine match position.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed when res_valid&res_ready.
- res_match  output  1  match result.
- res_index  output  5  match index.
- res_err  output  1  overflow, missing string or timeout.
- busy  output  1  high in any state other than LOAD.

Function
REQ-005 SHALL implement states LOAD, SEND_STR, SEND_PAT, GAP, WAIT, RESULT.
REQ-006 LOAD: in_ready=1; accepted characters SHALL be written to the string buffer (in_type=0) or pattern buffer (in_type=1) at that buffer's write pointer; host gaps (in_valid=0) mid-item SHALL be tolerated.
REQ-007 First accepted string character after a completed job SHALL clear the string length to 0 and set a str_new flag.
REQ-008 Characters beyond STR_MAX/PAT_MAX SHALL be discarded and set a sticky overflow flag; lengths saturate.
REQ-009 On accepted pattern character with in_last=1: next state SHALL be SEND_STR if str_new=1, else SEND_PAT if a string has been loaded since reset, else RESULT with res_err=1 and no engine activity.
REQ-010 A string character with in_last=1 SHALL only close the string; sequencer stays in LOAD.
REQ-011 SEND_STR: one character per cycle, eng_isstring=1, eng_chardata=strbuf[i], i=0..len-1 contiguous; then SEND_PAT; str_new cleared.
REQ-012 SEND_PAT: eng_ispattern=1, eng_chardata=patbuf[j], j=0..plen-1 contiguous; then GAP.
REQ-013 GAP: exactly one cycle with eng_isstring=eng_ispattern=0; then WAIT.
REQ-014 eng_isstring and eng_ispattern SHALL never be high together; eng_chardata SHALL be 0 when both low.
REQ-015 WAIT: a counter SHALL increment each cycle; on eng_valid=1 SHALL capture eng_match/eng_match_index into res_match/res_index and go RESULT; on counter reaching WAIT_LIMIT without eng_valid SHALL go RESULT with res_match=0, res_index=0, res_err=1.
REQ-016 eng_valid outside WAIT SHALL be ignored.
REQ-017 RESULT: res_valid=1 and res_* stable until res_ready=1; on handshake SHALL return to LOAD, clear pattern length, overflow flag and res_valid in the same edge.
REQ-018 res_err SHALL equal overflow OR missing-string OR timeout for the current job.
REQ-019 The string buffer SHALL persist across jobs so consecutive patterns reuse it without resending.

Reset
REQ-020 Reset SHALL force state LOAD; in_ready=1 after release; all eng_* outputs, res_*, busy, lengths, pointers, counters, str_new, string-loaded and overflow flags SHALL be 0.
REQ-021 Reset asserted in any state SHALL abort the job immediately with no further engine strobes; buffer contents need not be cleared.

Structure
REQ-022 Shared package sme_seq_pkg SHALL hold the state encoding and default constants STR_MAX, PAT_MAX, WAIT_LIMIT.
REQ-023 Buffer storage SHALL be one sub-module sme_char_buf (parameterised depth, write port, combinational read port, length output), instantiated twice.

Verification
REQ-024 String "ab cd" with in_last, pattern "cd" with in_last; engine model returns match=1,index=3 -> strobes a,b,space,c,d then c,d, one gap cycle, res_match=1, res_index=3, res_err=0.
REQ-025 Second pattern "^a" after REQ-024 without new string -> no eng_isstring cycles, only 2 eng_ispattern cycles, result passed through.
REQ-026 Pattern "x" as the first item after reset -> res_valid with res_err=1, no engine strobes.
REQ-027 10-character pattern -> only 8 sent, res_err=1; 40-character string -> 32 sent.
REQ-028 Engine never asserts eng_valid -> res_valid after 255 WAIT cycles, res_err=1, res_match=0.
REQ-029 res_ready held low 5 cycles, then reset asserted mid-SEND_STR on next job -> res_* held stable, then all outputs 0 immediately on reset.
